game_sequencer: RTL and testbench

Top-level game scheduler for the Dino datapath. Sequences the obstacle controller through idle/run/pause/over. Generates the one-cycle game_tick enable that paces obstacle scrolling and scoring. Shortens the tick period as score rises to ramp difficulty, and holds the session high score.

---
 rtl/game_sequencer.sv | 144 ++++++++++++++
 tb/tb_game_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game scheduler for the Dino datapath: idle/run/pause/over sequencing, tick pacing,
// score-driven difficulty ramp and session high score.
module game_sequencer #(
    parameter int unsigned BASE_PERIOD = 500000,
    parameter int unsigned MIN_PERIOD  = 200000,
    parameter int unsigned STEP        = 10000,
    parameter int unsigned SCORE_STEP  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        collide,
    input  logic [15:0] score,
    output logic        game_tick,
    output logic        over,
    output logic        obs_rst,
    output logic [1:0]  state,
    output logic [19:0] period,
    output logic [15:0] high_score
);

    localparam int unsigned PW = 20;
    localparam int unsigned SW = 16;
    localparam int unsigned TW = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic          start_q;
    logic          pause_q;
    logic [PW-1:0] count;
    logic [PW-1:0] count_nxt;
    logic [PW-1:0] period_nxt;
    logic [TW-1:0] threshold;
    logic [TW-1:0] threshold_nxt;
    logic [SW-1:0] high_score_nxt;
    logic          tick_nxt;
    logic          over_nxt;
    logic          obs_rst_nxt;

    logic start_rise;
    logic pause_rise;
    logic new_game;
    logic tick_due;
    logic level_up;

    assign start_rise = start & ~start_q;
    assign pause_rise = pause & ~pause_q;
    assign new_game   = ((cur_state == IDLE) || (cur_state == OVER)) && start_rise;
    // >= so a period shrink below the running count still ticks on the next cycle
    assign tick_due   = count >= (period - PW'(1));
    assign level_up   = {1'b0, score} >= threshold;
    assign state      = cur_state;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= IDLE;
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            count      <= '0;
            period     <= PW'(BASE_PERIOD);
            threshold  <= TW'(SCORE_STEP);
            high_score <= '0;
            game_tick  <= 1'b0;
            over       <= 1'b0;
            obs_rst    <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            start_q    <= start;
            pause_q    <= pause;
            count      <= count_nxt;
            period     <= period_nxt;
            threshold  <= threshold_nxt;
            high_score <= high_score_nxt;
            game_tick  <= tick_nxt;
            over       <= over_nxt;
            obs_rst    <= obs_rst_nxt;
        end
    end

    // Next-state logic; in RUN a collision outranks a pause request
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (start_rise) nxt_state = RUN;
            RUN: begin
                if (collide)         nxt_state = OVER;
                else if (pause_rise) nxt_state = PAUSE;
            end
            PAUSE:   if (pause_rise) nxt_state = RUN;
            OVER:    if (start_rise) nxt_state = RUN;
            default: nxt_state = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        count_nxt      = count;
        period_nxt     = period;
        threshold_nxt  = threshold;
        high_score_nxt = high_score;
        tick_nxt       = 1'b0;
        obs_rst_nxt    = 1'b0;
        over_nxt       = (nxt_state == OVER);

        if (new_game) begin
            obs_rst_nxt   = 1'b1;
            count_nxt     = '0;
            period_nxt    = PW'(BASE_PERIOD);
            threshold_nxt = TW'(SCORE_STEP);
        end

        if (cur_state == RUN) begin
            if (collide) begin
                if (score > high_score) high_score_nxt = score;
            end else if (!pause_rise) begin
                if (tick_due) begin
                    tick_nxt  = 1'b1;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + PW'(1);
                end
            end

            // One difficulty level per cycle; period saturates at MIN_PERIOD
            if (level_up) begin
                threshold_nxt = threshold + TW'(SCORE_STEP);
                if ({1'b0, period} >= 21'(MIN_PERIOD + STEP))
                    period_nxt = period - PW'(STEP);
                else
                    period_nxt = PW'(MIN_PERIOD);
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus random traffic
// compared each cycle against a rule-level reference model.
module tb_game_sequencer;

    localparam int unsigned BASE = 10;
    localparam int unsigned MINP = 4;
    localparam int unsigned STP  = 2;
    localparam int unsigned SS   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        collide = 1'b0;
    logic [15:0] score = 16'd0;
    logic        game_tick;
    logic        over;
    logic        obs_rst;
    logic [1:0]  state;
    logic [19:0] period;
    logic [15:0] high_score;
    logic [40:0] obs;

    game_sequencer #(
        .BASE_PERIOD(BASE),
        .MIN_PERIOD (MINP),
        .STEP       (STP),
        .SCORE_STEP (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .collide   (collide),
        .score     (score),
        .game_tick (game_tick),
        .over      (over),
        .obs_rst   (obs_rst),
        .state     (state),
        .period    (period),
        .high_score(high_score)
    );

    always #5 clk = ~clk;

    assign obs = {game_tick, over, obs_rst, state, period, high_score};

    int errors = 0;
    int checks = 0;

    // Reference model: game mode 0..3, tick count, period, level threshold, best score
    int m_st, m_cnt, m_per, m_thr, m_hs;
    bit m_tick, m_over, m_obs, m_sq, m_pq;

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_per = BASE; m_thr = SS; m_hs = 0;
        m_tick = 0; m_over = 0; m_obs = 0; m_sq = 0; m_pq = 0;
    endfunction

    function automatic void model_step();
        bit sr, pr;
        int ns, nper, nthr;
        sr = start && !m_sq;
        pr = pause && !m_pq;
        m_sq = start;
        m_pq = pause;
        ns = m_st; nper = m_per; nthr = m_thr;
        m_tick = 0; m_obs = 0;
        case (m_st)
            0, 3: if (sr) begin
                ns = 1; m_obs = 1; m_cnt = 0; nper = BASE; nthr = SS;
            end
            1: begin
                if (int'(score) >= m_thr) begin
                    nthr = m_thr + SS;
                    nper = (m_per - STP < MINP) ? MINP : m_per - STP;
                end
                if (collide) begin
                    ns = 3;
                    if (int'(score) > m_hs) m_hs = int'(score);
                end else if (pr) begin
                    ns = 2;
                end else if (m_cnt >= m_per - 1) begin
                    m_tick = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            2: if (pr) ns = 1;
            default: ;
        endcase
        m_per = nper; m_thr = nthr; m_st = ns;
        m_over = (ns == 3);
    endfunction

    function automatic logic [40:0] exp_vec();
        return {m_tick, m_over, m_obs, 2'(m_st), 20'(m_per), 16'(m_hs)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({game_tick, over, obs_rst, state} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {game_tick, over, obs_rst, state});
        end
        checks++;
        if (period !== 20'd10) begin
            errors++; $display("FAIL reset_period got=%0d exp=10", period);
        end
        checks++;
        if (high_score !== 16'd0) begin
            errors++; $display("FAIL reset_high_score got=%0d exp=0", high_score);
        end
        rst = 1'b1;
        model_reset();
        cycle();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_start_ticks();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (obs_rst !== 1'b1 || state !== 2'd1) begin
            errors++; $display("FAIL start_edge obs_rst=%b state=%0d exp obs_rst=1 state=1", obs_rst, state);
        end
        for (int i = 1; i <= 40; i++) begin
            cycle();
            checks++;
            if (game_tick !== (i % 10 == 0) || obs_rst !== 1'b0) begin
                errors++; $display("FAIL tick_spacing cyc=%0d tick=%b obs_rst=%b exp tick=%b obs_rst=0",
                                   i, game_tick, obs_rst, (i % 10 == 0));
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL start_run cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_difficulty();
        int ticks[$];
        int exp_per[4] = '{6, 4, 4, 4};
        score = 16'd5;
        cycle();
        checks++;
        if (period !== 20'd8) begin
            errors++; $display("FAIL level1_period got=%0d exp=8", period);
        end
        repeat (3) cycle();
        score = 16'd20;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (period !== 20'(exp_per[i])) begin
                errors++; $display("FAIL catchup_period step=%0d got=%0d exp=%0d", i, period, exp_per[i]);
            end
        end
        score = 16'd25;
        cycle();
        checks++;
        if (period !== 20'd4) begin
            errors++; $display("FAIL clamp_period got=%0d exp=4", period);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (game_tick) ticks.push_back(i);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL diff_run cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (ticks.size() < 4) begin
            errors++; $display("FAIL fast_tick_count got=%0d exp>=4", ticks.size());
        end
        for (int k = 1; k < ticks.size(); k++) begin
            checks++;
            if (ticks[k] - ticks[k-1] != 4) begin
                errors++; $display("FAIL fast_tick_gap got=%0d exp=4", ticks[k] - ticks[k-1]);
            end
        end
    endtask

    task automatic test_pause();
        int guard, held, lat, seen;
        guard = 0;
        while (m_cnt != 2 && guard < 20) begin
            cycle(); guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++; $display("FAIL pause_setup_timeout got=%0d exp<20", guard);
        end
        held = m_cnt;
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (state !== 2'd2 || game_tick !== 1'b0) begin
                errors++; $display("FAIL paused cyc=%0d state=%0d tick=%b exp state=2 tick=0", i, state, game_tick);
            end
        end
        pause = 1'b0;
        cycle();
        pause = 1'b1;
        cycle();
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL resume_state got=%0d exp=1", state);
        end
        lat = (int'(MINP) - 1 - held) + 1;
        seen = 0;
        for (int i = 1; i <= 50 && seen == 0; i++) begin
            cycle();
            if (game_tick) seen = i;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL resume_run cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (seen != lat) begin
            errors++; $display("FAIL resume_latency got=%0d exp=%0d", seen, lat);
        end
        pause = 1'b0;
        cycle();
    endtask

    task automatic test_collide();
        int guard;
        guard = 0;
        while (m_cnt < m_per - 1 && guard < 20) begin
            cycle(); guard++;
        end
        score = 16'd37;
        collide = 1'b1;
        start = 1'b1;
        cycle();
        collide = 1'b0;
        checks++;
        if (game_tick !== 1'b0 || state !== 2'd3 || over !== 1'b1) begin
            errors++; $display("FAIL collide_due tick=%b state=%0d over=%b exp tick=0 state=3 over=1",
                               game_tick, state, over);
        end
        checks++;
        if (high_score !== 16'd37) begin
            errors++; $display("FAIL collide_high_score got=%0d exp=37", high_score);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (state !== 2'd3 || obs !== exp_vec()) begin
                errors++; $display("FAIL over_hold cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        start = 1'b0;
        score = 16'd0;
        cycle();
        start = 1'b1;
        cycle();
        checks++;
        if (obs_rst !== 1'b1 || period !== 20'd10 || over !== 1'b0 || state !== 2'd1) begin
            errors++; $display("FAIL restart obs_rst=%b period=%0d over=%b state=%0d exp 1/10/0/1",
                               obs_rst, period, over, state);
        end
        start = 1'b0;
        cycle();
        checks++;
        if (obs_rst !== 1'b0) begin
            errors++; $display("FAIL restart_pulse_width got=%b exp=0", obs_rst);
        end
        for (int i = 0; i < 15; i++) begin
            if (i == 8) score = 16'd12;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL restart_run cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        collide = 1'b1;
        cycle();
        collide = 1'b0;
        checks++;
        if (high_score !== 16'd37 || state !== 2'd3) begin
            errors++; $display("FAIL keep_high_score hs=%0d state=%0d exp hs=37 state=3", high_score, state);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 11) == 0);
            pause   = ($urandom_range(0, 9) == 0) ? ~pause : pause;
            collide = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 149) == 0)
                score = 16'($urandom_range(0, 120));
            else if ($urandom_range(0, 3) == 0)
                score = score + 16'($urandom_range(0, 3));
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        start = 1'b0; pause = 1'b0; collide = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (m_st != 1 && guard < 20) begin
            if (m_st == 2) begin pause = 1'b0; cycle(); pause = 1'b1; cycle(); pause = 1'b0; end
            else begin start = 1'b0; cycle(); start = 1'b1; cycle(); start = 1'b0; end
            guard++;
        end
        score = 16'd90;
        collide = 1'b1;
        cycle();
        collide = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        score = 16'd3;
        guard = 0;
        while (!(m_tick && m_st == 1) && guard < 40) begin
            cycle(); guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++; $display("FAIL async_setup_timeout got=%0d exp<40", guard);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || period !== 20'd10 || high_score !== 16'd0 || game_tick !== 1'b0 ||
            over !== 1'b0 || obs_rst !== 1'b0) begin
            errors++; $display("FAIL async_reset state=%0d period=%0d hs=%0d tick=%b over=%b obs_rst=%b exp 0/10/0/0/0/0",
                               state, period, high_score, game_tick, over, obs_rst);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL post_reset got=%h exp=%h", obs, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_ticks();
        test_difficulty();
        test_pause();
        test_collide();
        test_restart();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
